// File: rtl/core_dmem_if.sv
// Core data-memory port bundle: request side driven by the core (master),
// ack/data/exception and busy driven by the responder (slave).
interface core_dmem_if #(
   parameter int RW = 16,
   parameter int AB = RW / 8
);
   logic          i_mem_req;
   logic          i_mem_we;
   logic [RW-1:0] i_mem_addr;
   logic [RW-1:0] i_mem_data;
   logic [AB-1:0] i_mem_sel;
   logic          i_mem_long;
   logic [7:0]    i_mem_addr_high;
   logic          o_mem_ack;
   logic [RW-1:0] o_mem_data;
   logic          o_mem_exception;
   logic          o_busy;

   modport master (
      output i_mem_req, i_mem_we, i_mem_addr, i_mem_data, i_mem_sel,
             i_mem_long, i_mem_addr_high,
      input  o_mem_ack, o_mem_data, o_mem_exception, o_busy
   );

   modport slave (
      input  i_mem_req, i_mem_we, i_mem_addr, i_mem_data, i_mem_sel,
             i_mem_long, i_mem_addr_high,
      output o_mem_ack, o_mem_data, o_mem_exception, o_busy
   );
endinterface

// File: rtl/core_dmem_responder.sv
// Core data-memory responder: word-addressed scratchpad behind a req/ack port,
// fixed wait states, out-of-window accesses acked with an exception.
module core_dmem_responder #(
   parameter int          DEPTH_LOG2  = 8,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [15:0] BASE_ADDR   = 16'h0000,
   parameter logic [7:0]  LONG_PAGE   = 8'h00
) (
   input logic       i_clk,
   input logic       i_rst,
   core_dmem_if.slave bus
);
   localparam int RW    = 16;
   localparam int AB    = RW / 8;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  we_q, hit_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [RW-1:0]         data_q;
   logic [AB-1:0]         sel_q;
   logic [RW-1:0]         mem_q [DEPTH];

   logic                  accept, hit_in, enter_ack;
   logic                  w_we, w_hit;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic [RW-1:0]         w_data;
   logic [AB-1:0]         w_sel;
   logic                  wr_en;
   logic [RW-1:0]         lane_mask;
   logic                  ack;

   assign accept = (state_q == S_IDLE) && bus.i_mem_req;
   assign hit_in = (bus.i_mem_addr[RW-1:DEPTH_LOG2] == BASE_ADDR[RW-1:DEPTH_LOG2]) &&
                   (!bus.i_mem_long || (bus.i_mem_addr_high == LONG_PAGE));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.i_mem_req) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = S_ACK;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES);
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_ACK;
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         we_q   <= bus.i_mem_we;
         hit_q  <= hit_in;
         idx_q  <= bus.i_mem_addr[DEPTH_LOG2-1:0];
         data_q <= bus.i_mem_data;
         sel_q  <= bus.i_mem_sel;
      end
   end

   // The store commits on the edge entering ACK; with no wait states that is
   // the accept edge itself, so the live inputs are used instead of the latches.
   assign enter_ack = (state_d == S_ACK) && (state_q != S_ACK);
   assign w_we   = (state_q == S_IDLE) ? bus.i_mem_we   : we_q;
   assign w_hit  = (state_q == S_IDLE) ? hit_in         : hit_q;
   assign w_idx  = (state_q == S_IDLE) ? bus.i_mem_addr[DEPTH_LOG2-1:0] : idx_q;
   assign w_data = (state_q == S_IDLE) ? bus.i_mem_data : data_q;
   assign w_sel  = (state_q == S_IDLE) ? bus.i_mem_sel  : sel_q;
   assign wr_en  = enter_ack && w_we && w_hit && !i_rst;

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         for (int b = 0; b < AB; b++) begin
            if (w_sel[b]) mem_q[w_idx][8*b +: 8] <= w_data[8*b +: 8];
         end
      end
   end

   always_comb begin
      lane_mask = '0;
      for (int b = 0; b < AB; b++) lane_mask[8*b +: 8] = {8{sel_q[b]}};
   end

   assign ack                 = (state_q == S_ACK);
   assign bus.o_mem_ack       = ack;
   assign bus.o_mem_data      = (ack && hit_q && !we_q) ? (mem_q[idx_q] & lane_mask) : '0;
   assign bus.o_mem_exception = ack && !hit_q;
   assign bus.o_busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_core_dmem_responder.sv
// Bench for core_dmem_responder: three instances (0, 1 and 3 wait states)
// driven from a vector table and hand sequences, acks checked by a scoreboard.
module tb_core_dmem_responder;
   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
      logic [1:0]  sel;
      logic        lng;
      logic [7:0]  ah;
      logic [15:0] exp_d;
      logic        exp_e;
   } vec_t;

   typedef struct {
      logic [15:0] d;
      logic        e;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst0 = 1'b1, rst1 = 1'b1, rst3 = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   ackcnt [3];
   exp_t sbq [3][$];
   vec_t tv [$];

   core_dmem_if if0 ();
   core_dmem_if if1 ();
   core_dmem_if if3 ();

   core_dmem_responder #(.WAIT_CYCLES(0)) u0 (.i_clk(clk), .i_rst(rst0), .bus(if0));
   core_dmem_responder #(.WAIT_CYCLES(1)) u1 (.i_clk(clk), .i_rst(rst1), .bus(if1));
   core_dmem_responder #(.WAIT_CYCLES(3)) u3 (.i_clk(clk), .i_rst(rst3), .bus(if3));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int i, input logic req, input logic we, input logic [15:0] a,
                          input logic [15:0] d, input logic [1:0] s, input logic l,
                          input logic [7:0] ah);
      case (i)
         0: begin
            if0.i_mem_req = req; if0.i_mem_we = we; if0.i_mem_addr = a; if0.i_mem_data = d;
            if0.i_mem_sel = s; if0.i_mem_long = l; if0.i_mem_addr_high = ah;
         end
         1: begin
            if1.i_mem_req = req; if1.i_mem_we = we; if1.i_mem_addr = a; if1.i_mem_data = d;
            if1.i_mem_sel = s; if1.i_mem_long = l; if1.i_mem_addr_high = ah;
         end
         default: begin
            if3.i_mem_req = req; if3.i_mem_we = we; if3.i_mem_addr = a; if3.i_mem_data = d;
            if3.i_mem_sel = s; if3.i_mem_long = l; if3.i_mem_addr_high = ah;
         end
      endcase
   endtask

   function automatic logic ack_of(input int i);
      case (i)
         0:       return if0.o_mem_ack;
         1:       return if1.o_mem_ack;
         default: return if3.o_mem_ack;
      endcase
   endfunction

   function automatic logic busy_of(input int i);
      case (i)
         0:       return if0.o_busy;
         1:       return if1.o_busy;
         default: return if3.o_busy;
      endcase
   endfunction

   task automatic observe(input int i, input logic ack, input logic [15:0] d, input logic e);
      exp_t x;
      if (ack === 1'b1) begin
         ackcnt[i]++;
         chk($sformatf("ack_expected[%0d]", i), sbq[i].size() != 0, 1);
         if (sbq[i].size() != 0) begin
            x = sbq[i].pop_front();
            chk($sformatf("ack_cycle[%0d]", i), cyc, x.cyc);
            chk($sformatf("ack_data[%0d]", i), d, x.d);
            chk($sformatf("ack_exc[%0d]", i), e, x.e);
         end
      end else begin
         chk($sformatf("idle_data[%0d]", i), d, 0);
         chk($sformatf("idle_exc[%0d]", i), e, 0);
      end
   endtask

   always @(negedge clk) begin
      observe(0, if0.o_mem_ack, if0.o_mem_data, if0.o_mem_exception);
      observe(1, if1.o_mem_ack, if1.o_mem_data, if1.o_mem_exception);
      observe(2, if3.o_mem_ack, if3.o_mem_data, if3.o_mem_exception);
   end

   task automatic addv(input logic we, input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] s, input logic l, input logic [7:0] ah,
                       input logic [15:0] ed, input logic ee);
      vec_t v;
      v.we = we; v.addr = a; v.data = d; v.sel = s; v.lng = l; v.ah = ah;
      v.exp_d = ed; v.exp_e = ee;
      tv.push_back(v);
   endtask

   // One complete transaction: hold req until ack, then one idle cycle.
   task automatic access(input int i, input int w, input vec_t v);
      exp_t e;
      bit   got;
      got = 1'b0;
      set_req(i, 1'b1, v.we, v.addr, v.data, v.sel, v.lng, v.ah);
      e.d = v.exp_d; e.e = v.exp_e; e.cyc = cyc + 1 + w;
      sbq[i].push_back(e);
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (k == 0) chk($sformatf("busy_after_accept[%0d]", i), busy_of(i), 1);
         if (ack_of(i) === 1'b1) got = 1'b1;
      end
      chk($sformatf("ack_seen[%0d]", i), got, 1);
      set_req(i, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 8'h00);
      @(negedge clk);
      chk($sformatf("busy_idle[%0d]", i), busy_of(i), 0);
   endtask

   // Request held continuously: n miss-loads, one ack every w+2 cycles.
   task automatic sweep(input int i, input int w, input int n);
      exp_t e;
      int   seen;
      int   c;
      seen = 0;
      c = cyc;
      set_req(i, 1'b1, 1'b0, 16'h0100, 16'h0, 2'b11, 1'b0, 8'h00);
      for (int k = 0; k < n; k++) begin
         e.d = 16'h0; e.e = 1'b1; e.cyc = c + 1 + w + k * (w + 2);
         sbq[i].push_back(e);
      end
      for (int k = 0; k < 100 && seen < n; k++) begin
         @(negedge clk);
         if (ack_of(i) === 1'b1) seen++;
      end
      chk($sformatf("sweep_acks[%0d]", i), seen, n);
      set_req(i, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 8'h00);
      repeat (w + 4) @(negedge clk);
      chk($sformatf("sweep_drained[%0d]", i), sbq[i].size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   a0;
      for (int i = 0; i < 3; i++) begin
         ackcnt[i] = 0;
         set_req(i, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 8'h00);
      end

      // we, addr, data, sel, long, addr_high, expected data, expected exception
      addv(1, 16'h0010, 16'hBEEF, 2'b11, 0, 8'h00, 16'h0000, 0);
      addv(0, 16'h0010, 16'h0000, 2'b11, 0, 8'h00, 16'hBEEF, 0);
      addv(1, 16'h0020, 16'h1234, 2'b11, 0, 8'h00, 16'h0000, 0);
      addv(1, 16'h0020, 16'hAB00, 2'b10, 0, 8'h00, 16'h0000, 0);
      addv(0, 16'h0020, 16'h0000, 2'b11, 0, 8'h00, 16'hAB34, 0);
      addv(0, 16'h0020, 16'h0000, 2'b01, 0, 8'h00, 16'h0034, 0);
      addv(0, 16'h0020, 16'h0000, 2'b10, 0, 8'h00, 16'hAB00, 0);
      addv(0, 16'h0100, 16'h0000, 2'b11, 0, 8'h00, 16'h0000, 1);
      addv(0, 16'h0010, 16'h0000, 2'b11, 1, 8'h05, 16'h0000, 1);
      addv(1, 16'h0110, 16'h0000, 2'b11, 0, 8'h00, 16'h0000, 1);
      addv(1, 16'h0010, 16'h0000, 2'b11, 1, 8'h05, 16'h0000, 1);
      addv(0, 16'h0010, 16'h0000, 2'b11, 0, 8'h00, 16'hBEEF, 0);
      addv(1, 16'h0030, 16'h7777, 2'b11, 1, 8'h00, 16'h0000, 0);
      addv(0, 16'h0030, 16'h0000, 2'b11, 1, 8'h00, 16'h7777, 0);
      addv(1, 16'h0030, 16'hFFFF, 2'b00, 0, 8'h00, 16'h0000, 0);
      addv(0, 16'h0030, 16'h0000, 2'b11, 0, 8'h00, 16'h7777, 0);
      addv(1, 16'h00FF, 16'hCAFE, 2'b11, 0, 8'h00, 16'h0000, 0);
      addv(0, 16'h00FF, 16'h0000, 2'b11, 0, 8'h00, 16'hCAFE, 0);
      addv(0, 16'h01FF, 16'h0000, 2'b11, 0, 8'h00, 16'h0000, 1);
      addv(0, 16'hFF30, 16'h0000, 2'b11, 0, 8'h00, 16'h0000, 1);

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_ack", {if0.o_mem_ack, if1.o_mem_ack, if3.o_mem_ack}, 0);
      chk("rst_data0", if0.o_mem_data, 0);
      chk("rst_data1", if1.o_mem_data, 0);
      chk("rst_data3", if3.o_mem_data, 0);
      chk("rst_exc", {if0.o_mem_exception, if1.o_mem_exception, if3.o_mem_exception}, 0);
      chk("rst_busy", {if0.o_busy, if1.o_busy, if3.o_busy}, 0);
      rst0 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_no_ack", ackcnt[0] + ackcnt[1] + ackcnt[2], 0);

      // Table-driven accesses on the one-wait-state instance
      foreach (tv[n]) access(1, 1, tv[n]);

      // Latency/throughput with req held continuously
      sweep(0, 0, 4);
      sweep(2, 3, 4);

      // Store then load on the zero-wait instance (write commits at accept edge)
      addv(1, 16'h0005, 16'h5A5A, 2'b11, 0, 8'h00, 16'h0000, 0);
      access(0, 0, tv[tv.size()-1]);
      addv(0, 16'h0005, 16'h0000, 2'b11, 0, 8'h00, 16'h5A5A, 0);
      access(0, 0, tv[tv.size()-1]);

      // Reset mid-transaction aborts the store
      addv(1, 16'h0040, 16'h1111, 2'b11, 0, 8'h00, 16'h0000, 0);
      access(2, 3, tv[tv.size()-1]);
      a0 = ackcnt[2];
      set_req(2, 1'b1, 1'b1, 16'h0040, 16'h5555, 2'b11, 1'b0, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst3 = 1'b1;
      set_req(2, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 8'h00);
      @(negedge clk);
      chk("midrst_busy", if3.o_busy, 0);
      rst3 = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst_no_ack", ackcnt[2] - a0, 0);
      addv(0, 16'h0040, 16'h0000, 2'b11, 0, 8'h00, 16'h1111, 0);
      access(2, 3, tv[tv.size()-1]);

      repeat (4) @(negedge clk);
      chk("sb_empty", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
